// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - ID/EX pipeline register bundle between decode and execute
// master drives the registered fields (decode_stage); slave consumes them (execute).
interface decode_stage_if #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 4
);
  logic                valid_id_ex;
  logic [ALU_OP_W-1:0] alu_op_id_ex;
  logic                alu_a_sel_id_ex;
  logic                alu_b_sel_id_ex;
  logic                mem_en_id_ex;
  logic                rd_en_id_ex;
  logic                rd_data_sel_id_ex;
  logic [DATA_W-1:0]   imm_id_ex;
  logic [REG_W-1:0]    rd_addr_id_ex;
  logic [DATA_W-1:0]   rs_data_id_ex;
  logic [DATA_W-1:0]   rt_data_id_ex;

  modport master (
    output valid_id_ex, alu_op_id_ex, alu_a_sel_id_ex, alu_b_sel_id_ex, mem_en_id_ex,
           rd_en_id_ex, rd_data_sel_id_ex, imm_id_ex, rd_addr_id_ex, rs_data_id_ex, rt_data_id_ex
  );

  modport slave (
    input valid_id_ex, alu_op_id_ex, alu_a_sel_id_ex, alu_b_sel_id_ex, mem_en_id_ex,
          rd_en_id_ex, rd_data_sel_id_ex, imm_id_ex, rd_addr_id_ex, rs_data_id_ex, rt_data_id_ex
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: field decode, control, branch resolve, hazard stall, ID/EX register
// Optional macro BRANCH_FWD_EN: forward the MEM-stage result into the branch comparator.
module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_if_id,
  input  logic [DATA_W-1:0]  pc_if_id,
  input  logic [31:0]        ir_if_id,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic               flush,
  input  logic               ex_mem_rd_en,
  input  logic [REG_W-1:0]   ex_mem_rd_addr,
  input  logic [DATA_W-1:0]  ex_mem_rd_data,
  output logic [REG_W-1:0]   rs_addr,
  output logic [REG_W-1:0]   rt_addr,
  output logic [DATA_W-1:0]  addr,
  output logic               jump,
  output logic               stall,
  decode_stage_if.master     id_ex
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0), ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2), ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4), ALU_LUI = ALU_OP_W'(5);

  logic [5:0]          opcode, funct;
  logic [REG_W-1:0]    rd_field;
  logic [DATA_W-1:0]   imm_ext, rs_zeroed, rt_zeroed, op_a, op_b;
  logic [ALU_OP_W-1:0] c_alu_op;
  logic                c_a_sel, c_b_sel, c_mem_en, c_rd_en, c_rd_data_sel, c_rd_addr_sel;
  logic                c_beq, c_bne, is_branch, equal, taken;
  logic                ex_writes, ex_match, luh, bh, bubble;
  logic                mem_writes, mem_match_rs, mem_match_rt;

  assign opcode   = ir_if_id[31:26];
  assign funct    = ir_if_id[5:0];
  assign rs_addr  = REG_W'(ir_if_id[25:21]);
  assign rt_addr  = REG_W'(ir_if_id[20:16]);
  assign rd_field = REG_W'(ir_if_id[15:11]);
  assign imm_ext  = DATA_W'($signed(ir_if_id[15:0]));
  assign addr     = pc_if_id + (imm_ext << 2);

  always_comb begin
    c_alu_op      = ALU_ADD;
    c_a_sel       = 1'b0;
    c_b_sel       = 1'b0;
    c_mem_en      = 1'b0;
    c_rd_en       = 1'b0;
    c_rd_data_sel = 1'b0;
    c_rd_addr_sel = 1'b0;
    c_beq         = 1'b0;
    c_bne         = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        c_rd_addr_sel = 1'b1;
        c_rd_en       = 1'b1;
        case (funct)
          FN_ADD:  c_alu_op = ALU_ADD;
          FN_SUB:  c_alu_op = ALU_SUB;
          FN_AND:  c_alu_op = ALU_AND;
          FN_OR:   c_alu_op = ALU_OR;
          FN_SLT:  c_alu_op = ALU_SLT;
          default: c_rd_en  = 1'b0;  // unknown funct (incl. all-zero NOP) is a no-op
        endcase
      end
      OP_ADDI: begin c_b_sel = 1'b1; c_rd_en = 1'b1; end
      OP_LUI:  begin c_alu_op = ALU_LUI; c_a_sel = 1'b1; c_b_sel = 1'b1; c_rd_en = 1'b1; end
      OP_LW:   begin c_b_sel = 1'b1; c_mem_en = 1'b1; c_rd_en = 1'b1; c_rd_data_sel = 1'b1; end
      OP_SW:   begin c_b_sel = 1'b1; c_mem_en = 1'b1; end
      OP_BEQ:  begin c_alu_op = ALU_SUB; c_beq = 1'b1; end
      OP_BNE:  begin c_alu_op = ALU_SUB; c_bne = 1'b1; end
      default: ;
    endcase
  end

  assign is_branch = c_beq | c_bne;
  assign rs_zeroed = (rs_addr == '0) ? '0 : rs_data;
  assign rt_zeroed = (rt_addr == '0) ? '0 : rt_data;

  assign ex_writes    = id_ex.valid_id_ex & id_ex.rd_en_id_ex & (id_ex.rd_addr_id_ex != '0);
  assign ex_match     = (id_ex.rd_addr_id_ex == rs_addr) | (id_ex.rd_addr_id_ex == rt_addr);
  assign luh          = ex_writes & id_ex.mem_en_id_ex & id_ex.rd_data_sel_id_ex & ex_match;
  assign mem_writes   = ex_mem_rd_en & (ex_mem_rd_addr != '0);
  assign mem_match_rs = mem_writes & (ex_mem_rd_addr == rs_addr);
  assign mem_match_rt = mem_writes & (ex_mem_rd_addr == rt_addr);

`ifdef BRANCH_FWD_EN
  assign op_a = mem_match_rs ? ex_mem_rd_data : rs_zeroed;
  assign op_b = mem_match_rt ? ex_mem_rd_data : rt_zeroed;
  assign bh   = is_branch & ex_writes & ex_match;
`else
  // Without the bypass, a branch must also wait for a MEM-stage producer to reach the register file.
  logic unused_fwd_data;
  assign unused_fwd_data = ^ex_mem_rd_data;
  assign op_a = rs_zeroed;
  assign op_b = rt_zeroed;
  assign bh   = is_branch & ((ex_writes & ex_match) | mem_match_rs | mem_match_rt);
`endif

  assign equal  = (op_a == op_b);
  assign taken  = (c_beq & equal) | (c_bne & ~equal);
  assign stall  = valid_if_id & ~flush & (luh | bh);
  assign jump   = taken & valid_if_id & ~stall & ~flush;
  assign bubble = flush | ~valid_if_id | stall;

  // Bubbles clear only the qualifying bits; payload fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex.valid_id_ex       <= 1'b0;
      id_ex.alu_op_id_ex      <= '0;
      id_ex.alu_a_sel_id_ex   <= 1'b0;
      id_ex.alu_b_sel_id_ex   <= 1'b0;
      id_ex.mem_en_id_ex      <= 1'b0;
      id_ex.rd_en_id_ex       <= 1'b0;
      id_ex.rd_data_sel_id_ex <= 1'b0;
      id_ex.imm_id_ex         <= '0;
      id_ex.rd_addr_id_ex     <= '0;
      id_ex.rs_data_id_ex     <= '0;
      id_ex.rt_data_id_ex     <= '0;
    end else if (bubble) begin
      id_ex.valid_id_ex  <= 1'b0;
      id_ex.rd_en_id_ex  <= 1'b0;
      id_ex.mem_en_id_ex <= 1'b0;
    end else begin
      id_ex.valid_id_ex       <= 1'b1;
      id_ex.alu_op_id_ex      <= c_alu_op;
      id_ex.alu_a_sel_id_ex   <= c_a_sel;
      id_ex.alu_b_sel_id_ex   <= c_b_sel;
      id_ex.mem_en_id_ex      <= c_mem_en;
      id_ex.rd_en_id_ex       <= c_rd_en;
      id_ex.rd_data_sel_id_ex <= c_rd_data_sel;
      id_ex.imm_id_ex         <= imm_ext;
      id_ex.rd_addr_id_ex     <= c_rd_addr_sel ? rd_field : rt_addr;
      id_ex.rs_data_id_ex     <= rs_zeroed;
      id_ex.rt_data_id_ex     <= rt_zeroed;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized checks of decode_stage against a mnemonic-level model
module tb_decode_stage;

  localparam int M_ADD = 0, M_SUB = 1, M_AND = 2, M_OR = 3, M_SLT = 4, M_ADDI = 5;
  localparam int M_LUI = 6, M_LW = 7, M_SW = 8, M_BEQ = 9, M_BNE = 10, M_NOP = 11;
`ifdef BRANCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_if_id = 1'b0;
  logic [31:0] pc_if_id = '0, ir_if_id = '0, rs_data = '0, rt_data = '0;
  logic        flush = 1'b0, ex_mem_rd_en = 1'b0;
  logic [4:0]  ex_mem_rd_addr = '0;
  logic [31:0] ex_mem_rd_data = '0;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] addr;
  logic        jump, stall;
  int          n_checks = 0, n_errors = 0;

  decode_stage_if #(.DATA_W(32), .REG_W(5), .ALU_OP_W(4)) bus ();

  decode_stage #(.DATA_W(32), .REG_W(5), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_if_id(valid_if_id), .pc_if_id(pc_if_id), .ir_if_id(ir_if_id),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .ex_mem_rd_en(ex_mem_rd_en),
    .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_rd_data(ex_mem_rd_data), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .addr(addr), .jump(jump), .stall(stall), .id_ex(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(int mn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [15:0] imm);
    case (mn)
      M_ADD:   return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      M_SUB:   return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      M_AND:   return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      M_OR:    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      M_SLT:   return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      M_ADDI:  return {6'h08, rs, rt, imm};
      M_LUI:   return {6'h0F, rs, rt, imm};
      M_LW:    return {6'h23, rs, rt, imm};
      M_SW:    return {6'h2B, rs, rt, imm};
      M_BEQ:   return {6'h04, rs, rt, imm};
      M_BNE:   return {6'h05, rs, rt, imm};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(logic v, logic [31:0] pc, logic [31:0] ir, logic [31:0] rsd, logic [31:0] rtd,
                       logic fl, logic xen, logic [4:0] xaddr, logic [31:0] xdata);
    valid_if_id = v; pc_if_id = pc; ir_if_id = ir; rs_data = rsd; rt_data = rtd;
    flush = fl; ex_mem_rd_en = xen; ex_mem_rd_addr = xaddr; ex_mem_rd_data = xdata;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.valid_id_ex !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", bus.valid_id_ex); end
    drive(1'b1, 32'h40, enc(M_ADDI, 5'd0, 5'd1, 5'd0, 16'd5), 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (bus.valid_id_ex !== 1'b1 || bus.imm_id_ex !== 32'd5 || bus.rd_addr_id_ex !== 5'd1)
      begin n_errors++; $display("FAIL addi_load got v=%0b imm=%h rd=%0d exp 1/5/1", bus.valid_id_ex, bus.imm_id_ex, bus.rd_addr_id_ex); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.valid_id_ex !== 1'b0 || bus.rd_en_id_ex !== 1'b0 || bus.imm_id_ex !== 32'd0)
      begin n_errors++; $display("FAIL async_reset got v=%0b rd_en=%0b imm=%h exp 0", bus.valid_id_ex, bus.rd_en_id_ex, bus.imm_id_ex); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid_id_ex !== 1'b0) begin n_errors++; $display("FAIL held_in_reset got %0b exp 0", bus.valid_id_ex); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.valid_id_ex !== 1'b1 || bus.rd_en_id_ex !== 1'b1 || bus.imm_id_ex !== 32'd5)
      begin n_errors++; $display("FAIL post_release got v=%0b rd_en=%0b imm=%h exp 1/1/5", bus.valid_id_ex, bus.rd_en_id_ex, bus.imm_id_ex); end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1'b1, 32'h4, enc(M_LW, 5'd1, 5'd2, 5'd0, 16'd0), 32'h10, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 32'h8, enc(M_ADD, 5'd2, 5'd2, 5'd3, 16'd0), 32'h1, 32'h1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall got %0b exp 1", stall); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid_id_ex !== 1'b0 || bus.rd_en_id_ex !== 1'b0 || bus.mem_en_id_ex !== 1'b0)
      begin n_errors++; $display("FAIL lu_bubble got v=%0b rd_en=%0b mem=%0b exp 0", bus.valid_id_ex, bus.rd_en_id_ex, bus.mem_en_id_ex); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_stall_len got %0b exp 0", stall); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid_id_ex !== 1'b1 || bus.rd_addr_id_ex !== 5'd3 || bus.rd_en_id_ex !== 1'b1)
      begin n_errors++; $display("FAIL lu_add_enters got v=%0b rd=%0d exp 1/3", bus.valid_id_ex, bus.rd_addr_id_ex); end
  endtask

  task automatic test_branch();
    apply_reset();
    drive(1'b1, 32'h100, enc(M_BEQ, 5'd4, 5'd5, 5'd0, 16'd3), 32'd7, 32'd7, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (jump !== 1'b1 || addr !== 32'h10C || stall !== 1'b0)
      begin n_errors++; $display("FAIL beq_taken got j=%0b addr=%h s=%0b exp 1/10c/0", jump, addr, stall); end
    ir_if_id = enc(M_BEQ, 5'd4, 5'd5, 5'd0, 16'hFFFF);
    #1;
    n_checks++; if (addr !== 32'h0FC || jump !== 1'b1) begin n_errors++; $display("FAIL beq_back got addr=%h j=%0b exp 0fc/1", addr, jump); end
    rt_data = 32'd8;
    #1;
    n_checks++; if (jump !== 1'b0) begin n_errors++; $display("FAIL beq_not_taken got %0b exp 0", jump); end
    valid_if_id = 1'b0; rt_data = 32'd7;
    #1;
    n_checks++; if (jump !== 1'b0) begin n_errors++; $display("FAIL beq_invalid got %0b exp 0", jump); end
  endtask

  task automatic test_branch_hazard();
    apply_reset();
    drive(1'b1, 32'h20, enc(M_ADD, 5'd1, 5'd2, 5'd4, 16'd0), 32'd3, 32'd4, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 32'h24, enc(M_BEQ, 5'd4, 5'd5, 5'd0, 16'd2), 32'd0, 32'd7, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (stall !== 1'b1 || jump !== 1'b0) begin n_errors++; $display("FAIL bh_ex got s=%0b j=%0b exp 1/0", stall, jump); end
    @(posedge clk); #1;
    drive(1'b1, 32'h24, enc(M_BEQ, 5'd4, 5'd5, 5'd0, 16'd2), 32'd0, 32'd7, 1'b0, 1'b1, 5'd4, 32'd7);
    #1;
    n_checks++; if (stall !== !FWD || jump !== FWD) begin n_errors++; $display("FAIL bh_mem got s=%0b j=%0b exp %0b/%0b", stall, jump, !FWD, FWD); end
    @(posedge clk); #1;
    if (!FWD) begin
      drive(1'b1, 32'h24, enc(M_BEQ, 5'd4, 5'd5, 5'd0, 16'd2), 32'd7, 32'd7, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      n_checks++; if (stall !== 1'b0 || jump !== 1'b1) begin n_errors++; $display("FAIL bh_resolve got s=%0b j=%0b exp 0/1", stall, jump); end
    end
  endtask

  task automatic test_flush_stall();
    apply_reset();
    drive(1'b1, 32'h4, enc(M_LW, 5'd1, 5'd2, 5'd0, 16'd0), 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 32'h8, enc(M_BEQ, 5'd2, 5'd2, 5'd0, 16'd1), 32'h5, 32'h5, 1'b1, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (stall !== 1'b0 || jump !== 1'b0) begin n_errors++; $display("FAIL flush_stall got s=%0b j=%0b exp 0/0", stall, jump); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid_id_ex !== 1'b0 || bus.rd_en_id_ex !== 1'b0) begin n_errors++; $display("FAIL flush_bubble got v=%0b exp 0", bus.valid_id_ex); end
  endtask

  task automatic test_reg_zero();
    apply_reset();
    drive(1'b1, 32'h4, enc(M_ADD, 5'd0, 5'd0, 5'd0, 16'd0), 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (bus.rs_data_id_ex !== 32'h0 || bus.rt_data_id_ex !== 32'h0 || bus.rd_addr_id_ex !== 5'd0)
      begin n_errors++; $display("FAIL r0_operands got rs=%h rt=%h rd=%0d exp 0", bus.rs_data_id_ex, bus.rt_data_id_ex, bus.rd_addr_id_ex); end
    drive(1'b1, 32'h8, enc(M_LW, 5'd1, 5'd0, 5'd0, 16'd0), 32'h1, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 32'hC, enc(M_BEQ, 5'd0, 5'd0, 5'd0, 16'd1), 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (stall !== 1'b0 || jump !== 1'b1) begin n_errors++; $display("FAIL r0_no_hazard got s=%0b j=%0b exp 0/1", stall, jump); end
  endtask

  typedef struct {
    logic v, a_sel, b_sel, mem_en, rd_en, rd_sel;
    logic [3:0] alu;
    logic [31:0] imm, rsd, rtd;
    logic [4:0] rd;
  } idex_t;

  task automatic test_random();
    idex_t m;
    int mn;
    logic [4:0] rs, rt, rd, xaddr;
    logic [31:0] w, pc, rsd, rtd, xdata, a, b, exp_addr;
    logic v, fl, xen, ex_hit, mem_hit, luh, bh, br, exp_stall, exp_jump, taken;
    apply_reset();
    m = '{default: '0};
    for (int i = 0; i < 400; i++) begin
      mn = $urandom_range(0, 11);
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      if (mn == M_NOP) begin rs = 0; rt = 0; rd = 0; end
      w = enc(mn, rs, rt, rd, 16'($urandom));
      pc = $urandom & 32'hFFFF_FFFC;
      rsd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2));
      rtd = 32'($urandom_range(0, 2));
      v = ($urandom_range(0, 9) != 0); fl = ($urandom_range(0, 11) == 0);
      xen = 1'($urandom_range(0, 1)); xaddr = 5'($urandom_range(0, 3)); xdata = 32'($urandom_range(0, 2));
      drive(v, pc, w, rsd, rtd, fl, xen, xaddr, xdata);
      br = (mn == M_BEQ || mn == M_BNE);
      ex_hit = m.v && m.rd_en && m.rd != 0 && (m.rd == rs || m.rd == rt);
      luh = ex_hit && m.mem_en && m.rd_sel;
      mem_hit = xen && xaddr != 0 && (xaddr == rs || xaddr == rt);
      bh = br && (ex_hit || (!FWD && mem_hit));
      exp_stall = v && !fl && (luh || bh);
      a = (rs == 0) ? 32'h0 : rsd;
      b = (rt == 0) ? 32'h0 : rtd;
      if (FWD && xen && xaddr != 0 && xaddr == rs) a = xdata;
      if (FWD && xen && xaddr != 0 && xaddr == rt) b = xdata;
      taken = (mn == M_BEQ) ? (a == b) : (mn == M_BNE) ? (a != b) : 1'b0;
      exp_jump = taken && v && !exp_stall && !fl;
      exp_addr = pc + 32'($signed(w[15:0])) * 4;
      #1;
      n_checks++; if (stall !== exp_stall || jump !== exp_jump || addr !== exp_addr || rs_addr !== rs || rt_addr !== rt)
        begin n_errors++; $display("FAIL rnd_comb[%0d] got s=%0b j=%0b addr=%h exp s=%0b j=%0b addr=%h", i, stall, jump, addr, exp_stall, exp_jump, exp_addr); end
      if (fl || !v || exp_stall) begin
        m.v = 0; m.rd_en = 0; m.mem_en = 0;
      end else begin
        m.v = 1;
        m.alu = (mn == M_SUB || br) ? 4'd1 : (mn == M_AND) ? 4'd2 : (mn == M_OR) ? 4'd3 :
                (mn == M_SLT) ? 4'd4 : (mn == M_LUI) ? 4'd5 : 4'd0;
        m.a_sel = (mn == M_LUI);
        m.b_sel = (mn inside {M_ADDI, M_LUI, M_LW, M_SW});
        m.mem_en = (mn == M_LW || mn == M_SW);
        m.rd_sel = (mn == M_LW);
        m.rd_en = (mn <= M_SLT) || (mn inside {M_ADDI, M_LUI, M_LW});
        m.rd = (mn <= M_SLT || mn == M_NOP) ? rd : rt;
        m.imm = 32'($signed(w[15:0]));
        m.rsd = (rs == 0) ? 32'h0 : rsd;
        m.rtd = (rt == 0) ? 32'h0 : rtd;
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.valid_id_ex !== m.v || bus.rd_en_id_ex !== m.rd_en || bus.mem_en_id_ex !== m.mem_en ||
          bus.alu_op_id_ex !== m.alu || bus.alu_a_sel_id_ex !== m.a_sel || bus.alu_b_sel_id_ex !== m.b_sel ||
          bus.rd_data_sel_id_ex !== m.rd_sel || bus.rd_addr_id_ex !== m.rd || bus.imm_id_ex !== m.imm ||
          bus.rs_data_id_ex !== m.rsd || bus.rt_data_id_ex !== m.rtd)
        begin n_errors++; $display("FAIL rnd_idex[%0d] got v=%0b rd_en=%0b mem=%0b alu=%0d rd=%0d imm=%h rs=%h rt=%h exp v=%0b rd_en=%0b mem=%0b alu=%0d rd=%0d imm=%h rs=%h rt=%h",
          i, bus.valid_id_ex, bus.rd_en_id_ex, bus.mem_en_id_ex, bus.alu_op_id_ex, bus.rd_addr_id_ex, bus.imm_id_ex, bus.rs_data_id_ex, bus.rt_data_id_ex,
          m.v, m.rd_en, m.mem_en, m.alu, m.rd, m.imm, m.rsd, m.rtd); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_branch_hazard();
    test_flush_stall();
    test_reg_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised MIPS instruction-decode stage. Sits between the fetch IF/ID register and execute.
- Decodes fields and drives the team `control` decoder.
- Resolves branches/jumps in ID; detects load-use and branch-operand hazards; issues stalls.
- Owns the ID/EX pipeline register, with a valid bit, bubble insertion, flush and asynchronous reset.

Parameters:
DATA_W, 32, datapath/PC width (>=16)
REG_W, 5, register-address width
ALU_OP_W, 4, ALU operation code width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_if_id  in  1  IF/ID holds a real instruction
pc_if_id  in  DATA_W  PC+4 of the ID instruction
ir_if_id  in  32  instruction word
rs_data  in  DATA_W  register-file read port A
rt_data  in  DATA_W  register-file read port B
flush  in  1  kill ID instruction (squash from later stage)
ex_mem_rd_en  in  1  MEM-stage instruction writes a register
ex_mem_rd_addr  in  REG_W  MEM-stage destination
ex_mem_rd_data  in  DATA_W  MEM-stage ALU result
rs_addr  out  REG_W  ir[25:21]
rt_addr  out  REG_W  ir[20:16]
addr  out  DATA_W  branch target
jump  out  1  redirect fetch to addr
stall  out  1  hold PC and IF/ID this cycle
valid_id_ex  out  1  ID/EX holds a real instruction
alu_op_id_ex  out  ALU_OP_W  ALU operation
alu_a_sel_id_ex, alu_b_sel_id_ex, mem_en_id_ex, rd_en_id_ex, rd_data_sel_id_ex  out  1 each  registered control
imm_id_ex  out  DATA_W  sign-extended imm[15:0]
rd_addr_id_ex  out  REG_W  destination (rd if rd_addr_sel, else rt)
rs_data_id_ex, rt_data_id_ex  out  DATA_W  operands; forced 0 when the address is 0

Behaviour:
- One clock `clk`; asynchronous active-low reset `rst_n`.
  - While rst_n=0, every ID/EX register is 0, including valid_id_ex.
  - Release is synchronous to the next clk edge.
- Combinational:
  - addr = pc_if_id + (sign-extended imm << 2), truncated to DATA_W; wraps modulo 2^DATA_W.
  - equal = (opA == opB). opA/opB are rs_data/rt_data, zeroed for register 0, optionally forwarded (see below).
- Load-use hazard (luh):
  - Condition: valid_id_ex & mem_en_id_ex & rd_data_sel_id_ex & rd_en_id_ex & rd_addr_id_ex!=0 & rd_addr_id_ex matches rs_addr or rt_addr.
- Branch hazard (bh):
  - Applies when the ID instruction is a branch (control uses equal).
  - Condition: valid_id_ex & rd_en_id_ex & nonzero rd_addr_id_ex matching rs_addr/rt_addr.
  - The EX result is not yet available, so the branch waits.
- stall = valid_if_id & ~flush & (luh | bh).
- jump = control.jump & valid_if_id & ~stall & ~flush. It is never asserted from an invalid or stalled slot.
- ID/EX register update each clk, in priority order:
  1. flush or ~valid_if_id or stall: insert bubble. valid_id_ex=0, rd_en_id_ex=0, mem_en_id_ex=0; other fields don't-care, but hold their previous value.
  2. Otherwise: load all decoded fields; valid_id_ex=1.
- Bubble rules:
  - A stall lasts as long as the hazard persists. A load-use stall normally lasts 1 cycle; a branch after load lasts 2 cycles.
  - flush during a stall: flush wins, bubble inserted, stall=0.
- Latency: 1 cycle from IF/ID to ID/EX. Branch redirect is 0-cycle combinational, so a 1-slot delay is implied.

Optional Feature:
- Macro BRANCH_FWD_EN.
- Defined:
  - opA/opB take ex_mem_rd_data when ex_mem_rd_en & ex_mem_rd_addr!=0 & the address matches.
  - A branch dependent on the MEM-stage result resolves with no stall.
- Undefined:
  - The ex_mem_* ports are still present but not used for forwarding.
  - bh additionally asserts when ex_mem_rd_en & nonzero ex_mem_rd_addr matches a branch source register.
  - Such a branch therefore stalls one extra cycle.
- luh and all ID/EX contents are identical in both builds.

Test Plan:
1. Reset mid-stream: run ADDI r1,r0,5, then drop rst_n asynchronously between edges → valid_id_ex, rd_en_id_ex, imm_id_ex read 0 immediately; after release the first instruction loads normally.
2. Load-use: LW r2,0(r1) then ADD r3,r2,r2 → stall=1 for exactly one cycle; bubble (valid_id_ex=0, rd_en_id_ex=0); ADD enters EX next cycle.
3. Branch taken: pc_if_id=0x100, BEQ r4,r5,+3, r4=r5=7, no hazard → jump=1, addr=0x10C. With imm=-1 → addr=0x0FC.
4. Branch after ALU write: ADD r4,.. in MEM, BEQ r4,r5 in ID, ex_mem_rd_data=7, rs_data=0, rt_data=7 → with BRANCH_FWD_EN: jump=1, stall=0. Without: stall=1 one cycle, jump=0 that cycle.
5. Flush during stall: luh active and flush=1 → stall=0, jump=0, valid_id_ex=0 next cycle.
6. Register zero: ADD r0,r0,r0 with rs_data=rt_data=0xDEADBEEF → rs_data_id_ex=rt_data_id_ex=0; rd_addr_id_ex=0 never triggers luh/bh.
